// File: rtl/bit_compare_pipe_pkg.sv
// Shared definitions for the bit_compare_pipe slice: comparison mode
// encoding and the default operand and counter widths.
package bit_compare_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_EQ = 2'b00,
        MODE_NE = 2'b01,
        MODE_LT = 2'b10,
        MODE_GT = 2'b11
    } mode_e;

endpackage

// File: rtl/bit_compare_pipe_if.sv
// Operand/result handshake bundle for bit_compare_pipe. The master side
// offers operand pairs and consumes results; the slave side is the pipe.
interface bit_compare_pipe_if
    import bit_compare_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic             z;
    logic [WIDTH-1:0] diff;

    modport master (
        output in_valid, A, B, mode, out_ready,
        input  in_ready, out_valid, z, diff
    );

    modport slave (
        input  in_valid, A, B, mode, out_ready,
        output in_ready, out_valid, z, diff
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that stops at its all-ones value instead of wrapping.
// A synchronous clear takes priority over an increment in the same cycle.
module sat_counter
    import bit_compare_pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Count events, holding at full scale; clear wins over a coincident event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/bit_compare_pipe.sv
// Two-stage unsigned comparator with valid/ready flow control.
// Stage 1 captures the operand pair with its mode; stage 2 holds the
// comparison result, the XOR difference and the equality flag used by the
// delivered-result counters and the sticky mismatch flag.
module bit_compare_pipe
    import bit_compare_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    bit_compare_pipe_if.slave bus,
    output logic [CNT_W-1:0]  eq_cnt,
    output logic [CNT_W-1:0]  ne_cnt,
    output logic              mism_seen
);

    function automatic logic cmp_result(input mode_e m,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        case (m)
            MODE_EQ: return a == b;
            MODE_NE: return a != b;
            MODE_LT: return a < b;
            MODE_GT: return a > b;
            default: return 1'b0;
        endcase
    endfunction

    logic             vld_p1;
    logic [WIDTH-1:0] a_p1;
    logic [WIDTH-1:0] b_p1;
    mode_e            mode_p1;

    logic             vld_p2;
    logic             z_p2;
    logic             eq_p2;
    logic [WIDTH-1:0] diff_p2;

    logic s2_load;
    logic s1_adv;
    logic in_rdy;
    logic accept;
    logic xfer;
    logic inc_eq;
    logic inc_ne;

    // Stage 2 can take a new pair when it is empty or its result leaves now;
    // stage 1 frees up in the same cycle it advances, giving full throughput.
    assign s2_load = !vld_p2 || bus.out_ready;
    assign s1_adv  = vld_p1 && s2_load;
    assign in_rdy  = !vld_p1 || s1_adv;
    assign accept  = bus.in_valid && in_rdy;
    assign xfer    = vld_p2 && bus.out_ready;
    assign inc_eq  = xfer && eq_p2;
    assign inc_ne  = xfer && !eq_p2;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = vld_p2;
    assign bus.z         = z_p2;
    assign bus.diff      = diff_p2;

    // ---- stage 1 boundary: operand capture ----

    // Stage valids: S1 fills on acceptance and empties on advance; S2 follows S1 when it may load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (accept) begin
                vld_p1 <= 1'b1;
            end else if (s1_adv) begin
                vld_p1 <= 1'b0;
            end
            if (s2_load) begin
                vld_p2 <= vld_p1;
            end
        end
    end

    // Capture the accepted pair together with the mode in force at acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1    <= bus.A;
            b_p1    <= bus.B;
            mode_p1 <= mode_e'(bus.mode);
        end
    end

    // ---- stage 2 boundary: comparison result ----

    // Evaluate the held pair as it moves into S2; the result then holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_p2    <= 1'b0;
            eq_p2   <= 1'b0;
            diff_p2 <= '0;
        end else if (s1_adv) begin
            z_p2    <= cmp_result(mode_p1, a_p1, b_p1);
            eq_p2   <= (a_p1 == b_p1);
            diff_p2 <= a_p1 ^ b_p1;
        end
    end

    // ---- delivered-result statistics ----

    sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc_eq),
        .cnt (eq_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_ne_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (inc_ne),
        .cnt (ne_cnt)
    );

    // Sticky flag raised by the first delivered mismatching pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mism_seen <= 1'b0;
        end else if (clr) begin
            mism_seen <= 1'b0;
        end else if (inc_ne) begin
            mism_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_compare_pipe.sv
// Testbench for bit_compare_pipe: directed vector table, hand-written
// stall / saturation / clear / reset sequences, and a randomized phase
// checked against a transaction-level model (queue of in-flight pairs).
module tb_bit_compare_pipe;
    import bit_compare_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic clr_s;
    logic [15:0] eq_cnt, ne_cnt;
    logic        mism_seen;
    logic [1:0]  eq_cnt_s, ne_cnt_s;
    logic        mism_seen_s;

    always #5 clk = ~clk;

    bit_compare_pipe_if #(.WIDTH(8)) bus ();
    bit_compare_pipe_if #(.WIDTH(8)) bus_s ();

    bit_compare_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus.slave),
        .eq_cnt(eq_cnt), .ne_cnt(ne_cnt), .mism_seen(mism_seen)
    );

    bit_compare_pipe #(.WIDTH(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .clr(clr_s), .bus(bus_s.slave),
        .eq_cnt(eq_cnt_s), .ne_cnt(ne_cnt_s), .mism_seen(mism_seen_s)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        logic       exp_z;
        logic [7:0] exp_diff;
    } vec_t;
    vec_t tbl[8];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] mode;
        int         age;
    } item_t;
    item_t q[$];
    int    m_eq   = 0;
    int    m_ne   = 0;
    bit    m_mism = 1'b0;
    logic  last_dut_acc;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic ref_z(input item_t it);
        int a, b;
        a = int'(it.a);
        b = int'(it.b);
        case (it.mode)
            2'd0:    return a == b;
            2'd1:    return a != b;
            2'd2:    return a < b;
            default: return a > b;
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.mode     = m;
    endtask

    // One clock: check the main DUT against the model, cross the edge, advance the model.
    task automatic tick();
        bit    exp_rdy, exp_ov, acc, xf;
        item_t it;
        #1;
        exp_rdy = (q.size() < 2) || bus.out_ready;
        exp_ov  = (q.size() > 0) && (q[0].age >= 1);
        check("in_ready", bus.in_ready, exp_rdy);
        check("out_valid", bus.out_valid, exp_ov);
        if (exp_ov) begin
            check("z", bus.z, ref_z(q[0]));
            check("diff", bus.diff, q[0].a ^ q[0].b);
        end
        check("eq_cnt", eq_cnt, m_eq);
        check("ne_cnt", ne_cnt, m_ne);
        check("mism_seen", mism_seen, m_mism);
        last_dut_acc = bus.in_valid & bus.in_ready;
        acc = bus.in_valid && exp_rdy;
        xf  = exp_ov && bus.out_ready;
        it.a = bus.A;
        it.b = bus.B;
        it.mode = bus.mode;
        it.age = 0;
        @(posedge clk);
        foreach (q[i]) q[i].age++;
        if (clr) begin
            m_eq = 0;
            m_ne = 0;
            m_mism = 1'b0;
        end else if (xf) begin
            if (q[0].a == q[0].b) begin
                if (m_eq < 65535) m_eq++;
            end else begin
                if (m_ne < 65535) m_ne++;
                m_mism = 1'b1;
            end
        end
        if (xf) void'(q.pop_front());
        if (acc) q.push_back(it);
        #1;
    endtask

    task automatic run_table(input int lo, input int n);
        for (int k = 0; k <= n; k++) begin
            if (k < n) set_in(1'b1, tbl[lo+k].a, tbl[lo+k].b, tbl[lo+k].mode);
            else       set_in(1'b0, 8'h00, 8'h00, 2'b00);
            tick();
            if (k >= 1) begin
                check("tbl_z", bus.z, tbl[lo+k-1].exp_z);
                check("tbl_diff", bus.diff, tbl[lo+k-1].exp_diff);
            end
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rb, hd;
        logic       hz;
        int         idx;
        item_t      st[3];

        tbl[0] = '{8'h00, 8'h00, MODE_EQ, 1'b1, 8'h00};
        tbl[1] = '{8'h01, 8'h01, MODE_EQ, 1'b1, 8'h00};
        tbl[2] = '{8'h02, 8'h00, MODE_EQ, 1'b0, 8'h02};
        tbl[3] = '{8'h03, 8'h02, MODE_EQ, 1'b0, 8'h01};
        tbl[4] = '{8'h05, 8'h09, MODE_LT, 1'b1, 8'h0C};
        tbl[5] = '{8'h05, 8'h09, MODE_GT, 1'b0, 8'h0C};
        tbl[6] = '{8'hA5, 8'h5A, MODE_EQ, 1'b0, 8'hFF};
        tbl[7] = '{8'h3C, 8'h3C, MODE_EQ, 1'b1, 8'h00};

        rst = 1'b0;
        clr = 1'b0;
        clr_s = 1'b0;
        set_in(1'b0, 8'h00, 8'h00, 2'b00);
        bus.out_ready = 1'b1;
        bus_s.in_valid = 1'b0;
        bus_s.A = 8'h00;
        bus_s.B = 8'h00;
        bus_s.mode = 2'b00;
        bus_s.out_ready = 1'b1;

        // Reset state, observed before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_z", bus.z, 1'b0);
        check("rst_diff", bus.diff, 8'h00);
        check("rst_eq_cnt", eq_cnt, 16'd0);
        check("rst_ne_cnt", ne_cnt, 16'd0);
        check("rst_mism", mism_seen, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Streamed equality vectors from reset, then counter totals
        run_table(0, 4);
        check("stream_eq_cnt", eq_cnt, 16'd2);
        check("stream_ne_cnt", ne_cnt, 16'd2);
        check("stream_mism", mism_seen, 1'b1);
        run_table(4, 4);

        // Live mode changes after acceptance must not affect the result
        set_in(1'b1, 8'h05, 8'h09, MODE_LT);
        tick();
        set_in(1'b0, 8'h05, 8'h09, MODE_GT);
        tick();
        check("lt_captured_mode", bus.z, 1'b1);
        set_in(1'b1, 8'h05, 8'h09, MODE_GT);
        tick();
        set_in(1'b0, 8'h05, 8'h09, MODE_LT);
        tick();
        check("gt_captured_mode", bus.z, 1'b0);
        tick();

        // Backpressure: 3 pairs offered while out_ready is low for 5 cycles
        st[0] = '{8'h11, 8'h22, MODE_NE, 0};
        st[1] = '{8'h33, 8'h33, MODE_EQ, 0};
        st[2] = '{8'h40, 8'h04, MODE_GT, 0};
        idx = 0;
        hz = 1'b0;
        hd = 8'h00;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (idx < 3) set_in(1'b1, st[idx].a, st[idx].b, st[idx].mode);
            else         set_in(1'b0, 8'h00, 8'h00, 2'b00);
            tick();
            if (last_dut_acc === 1'b1) idx++;
            if (k == 1) begin
                hz = bus.z;
                hd = bus.diff;
            end else if (k > 1) begin
                check("stall_z_stable", bus.z, hz);
                check("stall_diff_stable", bus.diff, hd);
            end
        end
        check("stall_accepted", idx, 2);
        check("stall_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (idx < 3) set_in(1'b1, st[idx].a, st[idx].b, st[idx].mode);
            else         set_in(1'b0, 8'h00, 8'h00, 2'b00);
            tick();
            if (last_dut_acc === 1'b1) idx++;
        end
        check("stall_all_accepted", idx, 3);
        check("stall_drained", bus.out_valid, 1'b0);

        // Narrow counters: saturation at 3, then clear against a transfer
        for (int k = 0; k < 8; k++) begin
            bus_s.in_valid = (k < 5);
            bus_s.A = 8'(k);
            bus_s.B = 8'(k);
            bus_s.mode = MODE_EQ;
            tick();
            if (k == 3) check("sat_eq_cnt_mid", eq_cnt_s, 2'd2);
        end
        check("sat_eq_cnt", eq_cnt_s, 2'd3);
        check("sat_ne_cnt", ne_cnt_s, 2'd0);
        bus_s.in_valid = 1'b1;
        bus_s.A = 8'h01;
        bus_s.B = 8'h02;
        tick();
        bus_s.in_valid = 1'b0;
        tick();
        check("clr_pre_valid", bus_s.out_valid, 1'b1);
        clr_s = 1'b1;
        tick();
        clr_s = 1'b0;
        check("clr_eq_cnt", eq_cnt_s, 2'd0);
        check("clr_ne_cnt", ne_cnt_s, 2'd0);
        check("clr_mism", mism_seen_s, 1'b0);
        check("clr_consumed", bus_s.out_valid, 1'b0);

        // Asynchronous reset with two pairs in flight
        bus.out_ready = 1'b0;
        set_in(1'b1, 8'h12, 8'h34, MODE_NE);
        tick();
        set_in(1'b1, 8'h56, 8'h56, MODE_EQ);
        tick();
        set_in(1'b0, 8'h00, 8'h00, 2'b00);
        rst = 1'b1;
        #2;
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        check("mid_rst_eq_cnt", eq_cnt, 16'd0);
        check("mid_rst_ne_cnt", ne_cnt, 16'd0);
        check("mid_rst_mism", mism_seen, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        m_eq = 0;
        m_ne = 0;
        m_mism = 1'b0;
        bus.out_ready = 1'b1;
        set_in(1'b1, 8'h10, 8'h20, MODE_LT);
        tick();
        set_in(1'b0, 8'h00, 8'h00, 2'b00);
        tick();
        check("post_rst_valid", bus.out_valid, 1'b1);
        check("post_rst_z", bus.z, 1'b1);
        check("post_rst_diff", bus.diff, 8'h30);
        tick();

        // Randomized traffic with backpressure and occasional clears
        for (int k = 0; k < 600; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            set_in($urandom_range(0, 3) != 0, ra, rb, 2'($urandom_range(0, 3)));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 40) == 0);
            tick();
        end
        clr = 1'b0;
        bus.out_ready = 1'b1;
        set_in(1'b0, 8'h00, 8'h00, 2'b00);
        for (int k = 0; k < 4; k++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_compare_pipe.md
BIT_COMPARE_PIPE -- requirements
Module: bit_compare_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; the legal range is 1 to 64.
REQ-002 Parameter CNT_W, default 16: width of each event counter; the legal range is 2 to 32.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port clr, input, 1 bit: synchronous clear of both counters and the sticky flag.
REQ-006 Port in_valid, input, 1 bit: an operand pair is offered.
REQ-007 Port in_ready, output, 1 bit: the block accepts the pair this cycle.
REQ-008 Port A, input, WIDTH bits: first operand, unsigned.
REQ-009 Port B, input, WIDTH bits: second operand, unsigned.
REQ-010 Port mode, input, 2 bits: 00 = equal, 01 = not-equal, 10 = A<B, 11 = A>B.
REQ-011 Port out_valid, output, 1 bit: a result is presented.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 Port z, output, 1 bit: the comparison result for the captured mode.
REQ-014 Port diff, output, WIDTH bits: bitwise A XOR B of the same pair as z.
REQ-015 Port eq_cnt, output, CNT_W bits: count of delivered results where A == B.
REQ-016 Port ne_cnt, output, CNT_W bits: count of delivered results where A != B.
REQ-017 Port mism_seen, output, 1 bit: sticky flag, set by the first delivered pair where A != B.

Function
REQ-018 Pipeline: two register stages, S1 (capture A, B, mode) and S2 (z, diff, eq flag).
- Each stage has its own valid bit.
REQ-019 Acceptance: a pair is accepted when in_valid & in_ready.
- Accepted pairs load S1 at the next edge.
REQ-020 Stage advance:
- S2 may load when S2 is empty, or when out_valid & out_ready.
- S1 advances into S2 only when S1 is valid and S2 may load.
REQ-021 Ready: in_ready = !S1_valid | S1_advance (combinational, full throughput).
REQ-022 Latency: with no backpressure, the result appears on out_valid exactly 2 cycles after acceptance.
REQ-023 Stall: while out_valid=1 and out_ready=0, z, diff and out_valid hold stable.
- S1 holds its pair and in_ready=0 once S1 is full.
REQ-024 Ordering: results leave in acceptance order; no pair is dropped or duplicated.
REQ-025 Comparison: the mode captured with the pair is used, not the live mode input.
- Unsigned, full WIDTH.
REQ-026 Counters: on each output transfer, increment eq_cnt if A == B, otherwise ne_cnt.
- Each counter saturates at 2^CNT_W - 1 (no wrap).
REQ-027 mism_seen: set on the first output transfer with A != B; remains 1 until clr or rst.
REQ-028 clr:
- Zeroes eq_cnt, ne_cnt and mism_seen at the next edge.
- clr has priority over a simultaneous transfer; that transfer is not counted.
- clr does not affect pipeline contents or handshakes.
REQ-029 out_valid=0 implies out_ready is ignored; no counter changes without a transfer.

Reset
REQ-030 rst asserted: S1_valid, S2_valid, out_valid, in_ready-gating state, z, diff, eq_cnt, ne_cnt and mism_seen all go to 0 immediately, without waiting for a clock edge.
REQ-031 Reset mid-operation discards all in-flight pairs.
- The first edge after deassertion may accept a new pair (in_ready=1 while the pipe is empty).

Structure
REQ-032 A shared package holds the mode encoding constants (MODE_EQ, MODE_NE, MODE_LT, MODE_GT) and the default WIDTH/CNT_W.
REQ-033 One sub-module, sat_counter (parameter CNT_W; inputs inc and clr), is instantiated twice, for eq_cnt and ne_cnt.

Verification
REQ-034 WIDTH=8, mode=00, pairs (0x00,0x00), (0x01,0x01), (0x02,0x00), (0x03,0x02) streamed with out_ready=1 -> z = 1,1,0,0 at cycles 2-5; eq_cnt=2, ne_cnt=2, mism_seen=1.
REQ-035 mode 10 with (0x05,0x09) -> z=1; mode 11 with the same pair -> z=0. A mode change after acceptance does not alter the result.
REQ-036 out_ready=0 for 5 cycles with 3 pairs offered -> 2 accepted, in_ready=0, z/diff stable. On release, results emerge in order and none is lost.
REQ-037 CNT_W=2, 5 equal pairs -> eq_cnt saturates at 3. clr asserted together with a transfer -> counters read 0 next cycle.
REQ-038 rst asserted mid-stream with 2 pairs in flight -> out_valid=0 and counters 0 without a clock edge. A new pair after release yields a correct result 2 cycles later.
REQ-039 diff check: (0xA5,0x5A) -> diff=0xFF; (0x3C,0x3C) -> diff=0x00 with z=1 in mode 00.
